// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the IF/ID pipeline register.
// Keeps the PC, issues one word read at a time over a valid/ready request
// channel, and presents {if_valid, if_pc, if_inst} downstream. A one-entry
// skid buffer absorbs a response that lands while the IF/ID register is
// stalled. A branch redirect flushes everything and retargets the PC. Any
// in-flight read issued before the redirect has its response dropped.

module fetch_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    // Downstream control
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,

    // Instruction memory request
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,

    // Instruction memory response
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,

    // IF/ID register
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
);

    typedef enum logic [0:0] {
        StReq,
        StWait
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] req_pc, req_pc_next;
    logic              drop, drop_next;

    logic              skid_valid, skid_valid_next;
    logic [ADDR_W-1:0] skid_pc, skid_pc_next;
    logic [INST_W-1:0] skid_inst, skid_inst_next;

    logic              out_valid_next;
    logic [ADDR_W-1:0] out_pc_next;
    logic [INST_W-1:0] out_inst_next;

    logic              req_fire;
    logic              rsp_here;
    logic              deliver;
    logic              adv;
    logic [ADDR_W-1:0] redirect_target;

    // Low bits of the redirect target are always forced to zero.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    // Request channel: only ask for a new word while there is room to hold it.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        if (!rst && (state == StReq) && !skid_valid) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {pc[ADDR_W-1:2], 2'b00};
        end
    end

    assign req_fire = mem_req_valid & mem_req_ready;
    // A response only counts while a read is actually outstanding.
    assign rsp_here = (state == StWait) & mem_rsp_valid;
    assign deliver  = rsp_here & ~drop;
    assign adv      = ~if_valid | ~stall_i;

    // Next-state for the fetch FSM, skid buffer and IF/ID register.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        req_pc_next     = req_pc;
        drop_next       = drop;
        skid_valid_next = skid_valid;
        skid_pc_next    = skid_pc;
        skid_inst_next  = skid_inst;
        out_valid_next  = if_valid;
        out_pc_next     = if_pc;
        out_inst_next   = if_inst;

        unique case (state)
            StReq: begin
                if (req_fire) begin
                    req_pc_next = pc;
                    pc_next     = pc + ADDR_W'(4);
                    state_next  = StWait;
                end
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    drop_next  = 1'b0;
                    state_next = StReq;
                end
            end
            default: begin
                state_next = StReq;
            end
        endcase

        if (adv) begin
            if (skid_valid) begin
                // Older skid entry goes out first; a fresh word refills the skid.
                out_valid_next  = 1'b1;
                out_pc_next     = skid_pc;
                out_inst_next   = skid_inst;
                skid_valid_next = deliver;
                if (deliver) begin
                    skid_pc_next   = req_pc;
                    skid_inst_next = mem_rsp_data;
                end
            end else if (deliver) begin
                out_valid_next = 1'b1;
                out_pc_next    = req_pc;
                out_inst_next  = mem_rsp_data;
            end else begin
                out_valid_next = 1'b0;
                out_pc_next    = '0;
                out_inst_next  = '0;
            end
        end else if (deliver) begin
            // Stalled: the skid is empty here since requests need an empty skid.
            skid_valid_next = 1'b1;
            skid_pc_next    = req_pc;
            skid_inst_next  = mem_rsp_data;
        end

        if (redirect_i) begin
            out_valid_next  = 1'b0;
            out_pc_next     = '0;
            out_inst_next   = '0;
            skid_valid_next = 1'b0;
            skid_pc_next    = '0;
            skid_inst_next  = '0;
            pc_next         = redirect_target;
            // A read still in flight (or just accepted) returns stale data later.
            if (((state == StWait) && !mem_rsp_valid) || req_fire) begin
                drop_next  = 1'b1;
                state_next = StWait;
            end else begin
                drop_next  = 1'b0;
                state_next = StReq;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StReq;
            pc         <= RESET_PC;
            req_pc     <= '0;
            drop       <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_inst    <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req_pc     <= req_pc_next;
            drop       <= drop_next;
            skid_valid <= skid_valid_next;
            skid_pc    <= skid_pc_next;
            skid_inst  <= skid_inst_next;
            if_valid   <= out_valid_next;
            if_pc      <= out_pc_next;
            if_inst    <= out_inst_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable memory model answers reads
// with address-derived data; the stimulus process pushes the expected PC
// stream into a queue and a negedge monitor pops and compares every
// instruction the downstream stage accepts.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic        mon_en = 1'b0;

    // Memory model state
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] paddr = '0;
    int          acc_cnt = 0;

    fetch_unit #(
        .ADDR_W  (64),
        .INST_W  (32),
        .RESET_PC(64'h1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: queue size <= arg, 1: mem_req_valid, 2: mem_rsp_valid, 3: if_valid
    task automatic wait_for(input string name, input int kind, input int arg);
        int  n;
        bit  ok;
        n = 0;
        ok = 0;
        while (!ok && n < 200) begin
            case (kind)
                0: ok = (exp_q.size() <= arg);
                1: ok = (mem_req_valid === 1'b1);
                2: ok = (mem_rsp_valid === 1'b1);
                default: ok = (if_valid === 1'b1);
            endcase
            if (!ok) begin
                tick();
                n++;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: waited %0d cycles", name, n);
            if (kind == 0) exp_q.delete();
        end
    endtask

    task automatic push_run(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
    endtask

    task automatic pulse_redirect(input logic [63:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        tick();
        redirect_i    = 1'b0;
    endtask

    // Memory: one read at a time, response 'lat' cycles after acceptance.
    always @(posedge clk) begin
        mem_rsp_valid <= 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                mem_rsp_valid <= 1'b1;
                mem_rsp_data  <= word_at(paddr);
                pend          <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            pend    <= 1'b1;
            cnt     <= lat;
            paddr   <= mem_req_addr;
            acc_cnt <= acc_cnt + 1;
        end
    end

    // Monitor: compare every instruction the downstream stage takes.
    always @(negedge clk) begin
        if (mon_en && !rst && !redirect_i && if_valid && !stall_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h expected none", if_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("if_pc", if_pc, e);
                chk("if_inst", {32'h0, if_inst}, {32'h0, word_at(e)});
            end
        end
    end

    initial begin
        int acc0;

        // Reset: everything visible must be zero.
        tick();
        tick();
        chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_inst", {32'h0, if_inst}, 64'h0);
        chk("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("rst_req_addr", mem_req_addr, 64'h0);

        // Sequential fetch from RESET_PC with 1-cycle memory.
        push_run(64'h1000, 8);
        mon_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk("first_req_addr", mem_req_addr, 64'h1000);
        wait_for("seq", 0, 4);

        // Stall while 0x1010 is presented: output holds, skid takes one word.
        wait_for("ifv", 3, 0);
        stall_i = 1'b1;
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold_valid", {63'h0, if_valid}, 64'h1);
            chk("stall_hold_pc", if_pc, 64'h1010);
        end
        chk("stall_no_req", {63'h0, mem_req_valid}, 64'h0);
        chk("stall_one_fetch", 64'(acc_cnt - acc0), 64'h1);
        stall_i = 1'b0;
        tick();
        chk("skid_out_valid", {63'h0, if_valid}, 64'h1);
        chk("skid_out_pc", if_pc, 64'h1014);
        wait_for("after_stall", 0, 0);

        // Redirect while waiting on a 3-cycle read.
        mon_en = 1'b0;
        lat = 3;
        wait_for("c_req", 1, 0);
        tick();
        exp_q.delete();
        push_run(64'h2000, 3);
        mon_en = 1'b1;
        pulse_redirect(64'h2003);
        chk("redir_wait_ifv", {63'h0, if_valid}, 64'h0);
        chk("redir_wait_noreq", {63'h0, mem_req_valid}, 64'h0);
        wait_for("c_req2", 1, 0);
        chk("redir_wait_addr", mem_req_addr, 64'h2000);
        wait_for("c_run", 0, 0);

        // Redirect in the same cycle as a response.
        mon_en = 1'b0;
        wait_for("d_rsp", 2, 0);
        exp_q.delete();
        push_run(64'h3000, 2);
        mon_en = 1'b1;
        pulse_redirect(64'h3000);
        chk("redir_rsp_ifv", {63'h0, if_valid}, 64'h0);
        chk("redir_rsp_req", {63'h0, mem_req_valid}, 64'h1);
        chk("redir_rsp_addr", mem_req_addr, 64'h3000);
        wait_for("d_run", 0, 0);

        // Redirect in the same cycle as a request handshake.
        mon_en = 1'b0;
        wait_for("e_req", 1, 0);
        exp_q.delete();
        push_run(64'h4000, 2);
        mon_en = 1'b1;
        pulse_redirect(64'h4000);
        chk("redir_hs_ifv", {63'h0, if_valid}, 64'h0);
        chk("redir_hs_noreq", {63'h0, mem_req_valid}, 64'h0);
        wait_for("e_req2", 1, 0);
        chk("redir_hs_addr", mem_req_addr, 64'h4000);
        wait_for("e_run", 0, 0);

        // PC wrap past the top of the address space.
        lat = 1;
        exp_q.delete();
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        pulse_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        wait_for("wrap", 0, 0);

        // Reset during a wait with stall held; the late response is ignored.
        mon_en = 1'b0;
        lat = 3;
        wait_for("g_req", 1, 0);
        tick();
        rst = 1'b1;
        stall_i = 1'b1;
        mem_req_ready = 1'b0;
        tick();
        chk("rst2_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rst2_if_pc", if_pc, 64'h0);
        chk("rst2_if_inst", {32'h0, if_inst}, 64'h0);
        chk("rst2_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("rst2_req_addr", mem_req_addr, 64'h0);
        rst = 1'b0;
        stall_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_rsp_ignored", {63'h0, if_valid}, 64'h0);
        end
        chk("restart_req", {63'h0, mem_req_valid}, 64'h1);
        chk("restart_addr", mem_req_addr, 64'h1000);
        exp_q.delete();
        push_run(64'h1000, 2);
        mon_en = 1'b1;
        mem_req_ready = 1'b1;
        wait_for("restart_run", 0, 0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that drives the IF/ID pipeline register.
- Generates the 64-bit ARMv8 PC and issues instruction-memory reads over a valid/ready request, valid-only response interface.
- Presents {if_valid, if_pc, if_inst} to IF/ID.
- Honours downstream stall and EX-stage branch redirect; one outstanding read, one-entry skid buffer.

Parameters:
ADDR_W, 64, PC/address width
INST_W, 32, instruction width
RESET_PC, 64'h0, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall_i  input  1  downstream cannot accept; hold if_* outputs
redirect_i  input  1  branch taken/flush, one-cycle pulse
redirect_pc_i  input  ADDR_W  new fetch address; bits [1:0] ignored (treated 0)
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  read address, word aligned
mem_rsp_valid  input  1  read data valid, latency >=1 cycle after accept
mem_rsp_data  input  INST_W  instruction word
if_valid  output  1  if_pc/if_inst hold a real instruction
if_pc  output  ADDR_W  PC of presented instruction
if_inst  output  INST_W  presented instruction

Behaviour:
- Reset (clk edge with rst=1): pc<=RESET_PC, state<=REQ, drop<=0, skid empty. All outputs 0 (if_valid, if_pc, if_inst, mem_req_valid, mem_req_addr). Reset overrides everything, including mid-transaction; a response arriving after reset for a pre-reset request is not counted as outstanding and is ignored.
- States:
  - REQ: mem_req_valid=1 and mem_req_addr=pc only when the skid is empty; otherwise mem_req_valid=0. When valid & ready: latch req_pc<=pc, pc<=pc+4 (mod 2^64, so FFFF_FFFF_FFFF_FFFC wraps to 0), go to WAIT.
  - WAIT: mem_req_valid=0. On mem_rsp_valid: if drop=1, discard the data and clear drop. Otherwise deliver {req_pc, mem_rsp_data}. Then go to REQ.
- Output advance condition: adv = !if_valid | !stall_i.
  - If adv and skid valid: out<=skid, skid cleared, any same-cycle delivery goes into the skid.
  - If adv and skid empty: out<=delivery if present; else if_valid<=0 and if_pc/if_inst<=0.
  - If !adv: out held unchanged; a delivery goes into the skid. The skid is always empty here because requests issue only with an empty skid.
- Throughput: 1 instruction per (memory latency + 1) cycles; no fetch issued while the skid is full.
- Redirect (redirect_i=1, highest priority after rst, overrides stall):
  - if_valid<=0, if_pc/if_inst<=0, skid cleared.
  - pc<={redirect_pc_i[ADDR_W-1:2],2'b00}.
  - If a request is outstanding (WAIT without rsp this cycle), or accepted this same cycle: drop<=1, state WAIT.
  - If the response arrives in the same cycle as redirect: it is discarded, drop stays 0, state REQ.
  - Otherwise state REQ.
  - The first request after redirect carries the new pc.
- Memory interface rule: mem_req_valid/addr stay stable until ready, unless a redirect changes pc. An unaccepted request may be retargeted.
- Exactly one outstanding request at any time.
- mem_rsp_valid outside WAIT is ignored.

Test Plan:
- Reset, RESET_PC=0x1000, 1-cycle memory returning addr-based data, stall_i=0 -> requests 0x1000, 0x1004, 0x1008...; if_pc matches with if_valid=1 one cycle after each rsp; if_inst correct.
- Hold stall_i=1 for 5 cycles while if_valid=1 -> if_* unchanged; exactly one more response captured in skid, no further mem_req_valid. Release -> skid instruction presented next cycle, fetch resumes in order with no loss or duplication.
- Redirect to 0x2003 while in WAIT with 3-cycle latency -> stale response discarded, if_valid=0. Next request addr 0x2000; first valid if_pc=0x2000.
- Redirect in the same cycle as mem_rsp_valid, and again in the same cycle as req handshake -> the same-cycle response is discarded; the accepted old request's response is later dropped; no stale if_valid.
- pc=0xFFFF_FFFF_FFFF_FFFC -> next request addr 0x0.
- Assert rst for 1 cycle in WAIT with stall_i=1 -> all outputs 0 next cycle, a late rsp is ignored, fetch restarts at RESET_PC.
